// File: rtl/serv_pc_seq.sv
// Serial PC sequencer: fetch handshake, 32-cycle serial execute/trap passes,
// and the strobes that drive the bit-serial PC datapath.
module serv_pc_seq #(
  parameter int FETCH_TIMEOUT = 16,
  parameter int CNT_W         = 5
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_run,
  input  logic i_ibus_ack,
  input  logic i_stall,
  input  logic i_bad_pc,
  input  logic i_jump,
  output logic o_ibus_cyc,
  output logic o_pc_en,
  output logic o_cnt0,
  output logic o_cnt1,
  output logic o_cnt2,
  output logic o_cnt3,
  output logic o_cnt12to31,
  output logic o_trap,
  output logic o_buserr,
  output logic o_misalign
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_TRAP
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_timer;
  logic             r_misalign;

  logic w_cnt_last;
  logic w_timeout;

  assign w_cnt_last = (r_cnt == '1);
  // Ack wins over timeout on the same cycle.
  assign w_timeout  = (FETCH_TIMEOUT != 0) && (r_state == S_FETCH) &&
                      !i_ibus_ack && (r_timer == TMO_LAST);

  assign o_ibus_cyc  = (r_state == S_FETCH);
  assign o_trap      = (r_state == S_TRAP);
  assign o_pc_en     = ((r_state == S_EXEC) || (r_state == S_TRAP)) && !i_stall;
  assign o_cnt0      = o_pc_en && (r_cnt == CNT_W'(0));
  assign o_cnt1      = o_pc_en && (r_cnt == CNT_W'(1));
  assign o_cnt2      = o_pc_en && (r_cnt == CNT_W'(2));
  assign o_cnt3      = o_pc_en && (r_cnt == CNT_W'(3));
  assign o_cnt12to31 = o_pc_en && (r_cnt >= CNT_W'(12));
  assign o_buserr    = w_timeout;
  assign o_misalign  = (r_state == S_EXEC) && o_pc_en && w_cnt_last && r_misalign;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_timer    <= '0;
      r_misalign <= 1'b0;
    end else begin
      // Counter wraps naturally at all-ones, so each pass starts at zero.
      if (o_pc_en) r_cnt <= r_cnt + CNT_W'(1);
      case (r_state)
        S_IDLE: begin
          if (i_run) begin
            r_state    <= S_FETCH;
            r_timer    <= '0;
            r_misalign <= 1'b0;
          end
        end
        S_FETCH: begin
          r_timer <= r_timer + 8'd1;
          if (i_ibus_ack)     r_state <= S_DECODE;
          else if (w_timeout) r_state <= S_TRAP;
        end
        S_DECODE: r_state <= S_EXEC;
        S_EXEC: begin
          if (o_pc_en && (r_cnt == CNT_W'(1))) r_misalign <= i_bad_pc && i_jump;
          if (o_pc_en && w_cnt_last) begin
            if (r_misalign) begin
              r_state <= S_TRAP;
            end else if (i_run) begin
              r_state    <= S_FETCH;
              r_timer    <= '0;
              r_misalign <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_TRAP: begin
          if (o_pc_en && w_cnt_last) begin
            if (i_run) begin
              r_state    <= S_FETCH;
              r_timer    <= '0;
              r_misalign <= 1'b0;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serv_pc_seq.sv
// Scoreboard bench for serv_pc_seq: stimulus queues hand-derived expected
// output vectors per cycle, a monitor pops and compares on the falling edge.
`timescale 1ns/1ps
module tb_serv_pc_seq;

  logic clk = 1'b0;
  logic i_rst_n, i_run, i_ibus_ack, i_stall, i_bad_pc, i_jump;
  logic o_ibus_cyc, o_pc_en, o_cnt0, o_cnt1, o_cnt2, o_cnt3, o_cnt12to31;
  logic o_trap, o_buserr, o_misalign;
  logic [9:0] w_outs;

  always #5 clk = ~clk;

  serv_pc_seq #(.FETCH_TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_run(i_run), .i_ibus_ack(i_ibus_ack),
    .i_stall(i_stall), .i_bad_pc(i_bad_pc), .i_jump(i_jump),
    .o_ibus_cyc(o_ibus_cyc), .o_pc_en(o_pc_en), .o_cnt0(o_cnt0),
    .o_cnt1(o_cnt1), .o_cnt2(o_cnt2), .o_cnt3(o_cnt3),
    .o_cnt12to31(o_cnt12to31), .o_trap(o_trap), .o_buserr(o_buserr),
    .o_misalign(o_misalign)
  );

  // {cyc, pc_en, cnt0, cnt1, cnt2, cnt3, cnt12to31, trap, buserr, misalign}
  assign w_outs = {o_ibus_cyc, o_pc_en, o_cnt0, o_cnt1, o_cnt2, o_cnt3,
                   o_cnt12to31, o_trap, o_buserr, o_misalign};

  localparam logic [9:0] ZERO   = 10'b00_0000_0000;
  localparam logic [9:0] CYC    = 10'b10_0000_0000;
  localparam logic [9:0] BUSERR = 10'b00_0000_0010;

  typedef struct {
    logic [9:0] v;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic logic [9:0] pv(int k, bit trap, bit mis);
    return {1'b0, 1'b1, k == 0, k == 1, k == 2, k == 3, k >= 12,
            trap, 1'b0, mis && (k == 31)};
  endfunction

  task automatic check(string name, logic [9:0] got, logic [9:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  task automatic step(logic run, logic ack, logic stall, logic bad, logic jmp,
                      logic [9:0] exp, string tag);
    exp_t e;
    i_run = run; i_ibus_ack = ack; i_stall = stall; i_bad_pc = bad; i_jump = jmp;
    e.v = exp; e.tag = tag;
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  // Enters already in FETCH; ack on the n-th cycle, then one DECODE cycle.
  task automatic fetch(int n, string tag);
    for (int i = 0; i < n - 1; i++) step(1, 0, 0, 0, 0, CYC, $sformatf("%s_f%0d", tag, i));
    step(1, 1, 0, 0, 0, CYC, $sformatf("%s_fack", tag));
    step(1, 0, 0, 0, 0, ZERO, $sformatf("%s_dec", tag));
  endtask

  task automatic pass(string tag, bit trap, bit mis, bit run_drop);
    for (int k = 0; k < 32; k++)
      step(!(run_drop && k >= 5), 0, 0, mis && k == 1, mis && k == 1,
           pv(k, trap, mis), $sformatf("%s_k%0d", tag, k));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        check(e.tag, w_outs, e.v);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: bench did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stim
    i_rst_n = 1'b0; i_run = 1'b0; i_ibus_ack = 1'b0;
    i_stall = 1'b0; i_bad_pc = 1'b0; i_jump = 1'b0;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0, ZERO, "reset0");
    step(1, 1, 0, 0, 0, ZERO, "reset1");
    i_rst_n = 1'b1;
    step(0, 1, 0, 0, 0, ZERO, "idle_ack0");
    step(0, 1, 0, 0, 0, ZERO, "idle_ack1");
    step(1, 0, 0, 0, 0, ZERO, "idle_run");

    // Ack on third FETCH cycle, full pass, FETCH again right after.
    fetch(3, "s1");
    pass("s1", 0, 0, 0);

    // Five stall cycles with cnt at 7.
    fetch(1, "stall");
    for (int k = 0; k < 7; k++) step(1, 0, 0, 0, 0, pv(k, 0, 0), $sformatf("stall_k%0d", k));
    for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, ZERO, $sformatf("stall_h%0d", i));
    for (int k = 7; k < 32; k++) step(1, 0, 0, 0, 0, pv(k, 0, 0), $sformatf("stall_k%0d", k));

    // Bad jump outside cnt==1, and bad_pc alone at cnt==1: no trap.
    fetch(1, "near");
    for (int k = 0; k < 32; k++)
      step(1, 0, 0, k <= 2, k != 1 && k <= 2, pv(k, 0, 0), $sformatf("near_k%0d", k));

    // Misaligned jump latched at cnt==1 -> misalign pulse, trap pass.
    fetch(2, "mis");
    pass("mis", 0, 1, 0);
    pass("mis_trap", 1, 0, 0);

    // Fetch timeout on 16th cycle -> buserr then trap pass.
    for (int i = 0; i < 15; i++) step(1, 0, 0, 0, 0, CYC, $sformatf("tmo_f%0d", i));
    step(1, 0, 0, 0, 0, CYC | BUSERR, "tmo_f15");
    pass("tmo_trap", 1, 0, 0);

    // Ack on 16th cycle has priority over timeout.
    fetch(16, "ackprio");
    pass("ackprio", 0, 0, 0);

    // i_run dropped mid-pass: pass completes, then IDLE.
    fetch(1, "rdrop");
    pass("rdrop", 0, 0, 1);
    step(0, 1, 0, 0, 0, ZERO, "rdrop_idle0");
    step(0, 0, 0, 0, 0, ZERO, "rdrop_idle1");
    step(1, 0, 0, 0, 0, ZERO, "rdrop_run");

    // Asynchronous reset at EXEC cnt==20.
    fetch(1, "rst");
    for (int k = 0; k < 20; k++) step(1, 0, 0, 0, 0, pv(k, 0, 0), $sformatf("rst_k%0d", k));
    #1;
    check("rst_pre_cnt20", w_outs, pv(20, 0, 0));
    i_rst_n = 1'b0;
    #1;
    check("rst_async_zero", w_outs, ZERO);
    @(posedge clk); #1;
    step(1, 0, 0, 0, 0, ZERO, "rst_hold");
    i_rst_n = 1'b1;
    step(1, 0, 0, 0, 0, ZERO, "rel_idle");
    step(1, 1, 0, 0, 0, CYC, "rel_fetch");
    step(1, 0, 0, 0, 0, ZERO, "rel_dec");
    pass("rel", 0, 0, 0);

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
